// File: rtl/if_fetch_buffer_pkg.sv
// Shared types and sizing for the instruction fetch buffer.
package if_pkg;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_buffer_if.sv
// Fetch buffer bus: PC hold, instruction memory port and decode-side output.
interface if_fetch_buffer_if;

  logic [31:0] pc_val;
  logic        hold_pc;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall_id;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc4;

  // Environment side: PC register, branch unit, memory and decode.
  modport master (
    output pc_val, flush, imem_ack, imem_rdata, stall_id,
    input  hold_pc, imem_req, imem_addr, inst_valid, inst_out, inst_pc, inst_pc4
  );

  // Fetch buffer side.
  modport slave (
    input  pc_val, flush, imem_ack, imem_rdata, stall_id,
    output hold_pc, imem_req, imem_addr, inst_valid, inst_out, inst_pc, inst_pc4
  );

endinterface

// File: rtl/if_fetch_buffer_inst_fifo.sv
// Synchronous FIFO of fetched {pc, inst} entries with clear and head read.
module inst_fifo
  import if_pkg::fetch_entry_t;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq_i,
  input  logic                     deq_i,
  input  logic                     clr_i,
  input  fetch_entry_t             data_i,
  output fetch_entry_t             head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  fetch_entry_t     mem_q [DEPTH];

  // Pointer and occupancy update; clear wins over enqueue/dequeue.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (deq_i) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (enq_i && !deq_i)      count_d = count_q + CNT_W'(1);
      else if (!enq_i && deq_i) count_d = count_q - CNT_W'(1);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful below the count.
  always_ff @(posedge clk) begin
    if (enq_i && !clr_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/if_fetch_buffer.sv
// Instruction fetch buffer: issues imem requests, queues fetched words for decode.
module if_fetch_buffer
  import if_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  if_fetch_buffer_if.slave   bus
);

  fetch_state_t     state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   occ_after;
  logic             fire;
  logic             deq;
  fetch_entry_t     entry_in;
  fetch_entry_t     head;

  assign fire      = (state_q == REQ) && bus.imem_ack && !bus.flush;
  assign deq       = bus.inst_valid && !bus.stall_id && !bus.flush;
  assign entry_in  = {addr_q, bus.imem_rdata};
  // Occupancy after this cycle's enqueue/dequeue, used to decide whether to keep fetching.
  assign occ_after = {1'b0, count} + (CNT_W+1)'(1) - (CNT_W+1)'(deq);

  inst_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .enq_i   (fire),
    .deq_i   (deq),
    .clr_i   (bus.flush),
    .data_i  (entry_in),
    .head_o  (head),
    .count_o (count)
  );

  // Fetch FSM next state and request address.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (!bus.flush && (count < CNT_W'(DEPTH))) begin
          state_d = REQ;
          addr_d  = bus.pc_val;
        end
      end
      REQ: begin
        if (bus.flush) begin
          state_d = bus.imem_ack ? IDLE : DROP;
        end else if (bus.imem_ack) begin
          if (occ_after < (CNT_W+1)'(DEPTH)) addr_d  = bus.pc_val + 32'd4;
          else                               state_d = IDLE;
        end
      end
      DROP: begin
        // Outstanding request from before a redirect: wait for its ack and discard it.
        if (bus.imem_ack && !bus.flush) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Fetch FSM state and address registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // PC advances on an accepted fetch or loads the branch target on flush.
  assign bus.hold_pc    = !(fire || bus.flush);
  assign bus.imem_req   = (state_q != IDLE);
  assign bus.imem_addr  = addr_q;
  assign bus.inst_valid = (count != '0);
  assign bus.inst_out   = head.inst;
  assign bus.inst_pc    = head.pc;
  assign bus.inst_pc4   = head.pc + 32'd4;

endmodule

// File: doc/if_fetch_buffer.md
IF_FETCH_BUFFER -- requirements
Module: if_fetch_buffer

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 pc_val  input  32  current PC from the PC register; advances only in cycles where hold_pc=0.
REQ-004 hold_pc  output  1  freezes the PC register when 1.
REQ-005 flush  input  1  taken branch/jump this cycle; the PC register loads the target in the same cycle.
REQ-006 imem_req  output  1  instruction memory request; held high until imem_ack.
REQ-007 imem_addr  output  32  registered request address; stable while imem_req=1.
REQ-008 imem_ack  input  1  memory completes the request; imem_rdata valid in that cycle.
REQ-009 imem_rdata  input  32  fetched instruction word.
REQ-010 stall_id  input  1  decode cannot accept an instruction this cycle.
REQ-011 inst_valid  output  1  FIFO head is valid.
REQ-012 inst_out  output  32  head instruction.
REQ-013 inst_pc  output  32  PC of the head instruction.
REQ-014 inst_pc4  output  32  inst_pc+4, modulo 2^32.

Function
REQ-015 The block shall contain a FIFO of DEPTH=4 entries {pc, inst}, with a 3-bit count and 2-bit wrapping read/write pointers.
REQ-016 The FSM shall have states IDLE, REQ and DROP; imem_req=1 in REQ and DROP only.
REQ-017 IDLE->REQ occurs when !flush and count<DEPTH, loading imem_addr<=pc_val.
REQ-018 fire is defined as state==REQ && imem_ack && !flush.
REQ-019 On fire, the FIFO shall enqueue {imem_addr, imem_rdata}.
REQ-020 On fire, if (count+1-deq)<DEPTH, the FSM stays in REQ with imem_addr<=pc_val+4; otherwise it goes to IDLE.
REQ-021 hold_pc shall be combinational: hold_pc = !(fire || flush).
REQ-022 Consequently, the PC advances exactly once per accepted instruction, or redirects on flush.
REQ-023 In REQ with flush && imem_ack, the rdata shall be discarded and the FSM goes to IDLE.
REQ-024 In REQ with flush && !imem_ack, the FSM goes to DROP.
REQ-025 In DROP, imem_ack returns the FSM to IDLE with the data discarded; a flush while in DROP keeps it in DROP.
REQ-026 In IDLE, imem_ack shall be ignored.
REQ-027 Dequeue (deq) occurs when inst_valid && !stall_id && !flush; the read pointer increments.
REQ-028 On flush, count and both pointers shall clear next edge, overriding any enqueue or dequeue.
REQ-029 inst_valid shall equal (count!=0); inst_out, inst_pc and inst_pc4 are read combinationally from the head entry.
REQ-030 A simultaneous enqueue and dequeue leaves count unchanged; enqueue at count==DEPTH is impossible by construction.
REQ-031 Back-to-back single-cycle acks shall sustain one instruction per cycle while decode drains.

Reset
REQ-032 rst shall force state=IDLE, count=0, pointers=0 and imem_addr=0.
REQ-033 Consequently, after reset imem_req=0, inst_valid=0 and hold_pc=1 (absent flush).
REQ-034 A rst asserted mid-request shall abandon the request; the memory shall tolerate a dropped req, and any late ack is ignored in IDLE.

Structure
REQ-035 Package if_pkg shall hold DEPTH, the fetch_state_t enum {IDLE, REQ, DROP}, and the fetch_entry_t struct {pc[31:0], inst[31:0]}.
REQ-036 The storage shall be sub-module inst_fifo: a synchronous FIFO with enq, deq, clr, count and a head output, parameterised by DEPTH.

Verification
REQ-037 Test 1: after reset, pc_val=0x0000_0000 and imem_ack tied high -> inst_pc sequence is 0x0, 0x4, 0x8 in consecutive cycles, and hold_pc=0 each fire cycle.
REQ-038 Test 2: stall_id=1 held, ack always 1 -> exactly 4 entries; then imem_req=0, hold_pc=1 and pc_val frozen at 0x10.
REQ-039 Test 3: flush at count=3 with the REQ ack pending -> next cycle inst_valid=0, state=DROP; the late ack is discarded, and the next request uses the target address 0x0000_0400.
REQ-040 Test 4: flush in the same cycle as imem_ack -> data not enqueued, count=0, state=IDLE, and hold_pc=0 in that cycle.
REQ-041 Test 5: count=4 with stall_id dropping to 0 and ack high -> dequeue occurs, re-request at imem_addr=pc_val, and count returns to 4 under sustained flow.
REQ-042 Test 6: rst asserted while in REQ at imem_addr=0x20 -> imem_req=0 and count=0 immediately; a subsequent ack has no effect.
